// File: rtl/freq_meas_sequencer_if.sv
// Handshake bundle between the host command FIFO and freq_meas_sequencer.
//   cmd_valid/cmd_ready  command offer/accept (cmd_chan, cmd_ncycles)
//   res_valid/res_ready  result offer/accept  (res_chan, res_count, res_err)
// master = host side, slave = sequencer side.
interface freq_meas_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_W       = 2
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [CH_W-1:0]       cmd_chan;
    logic [DATA_WIDTH-1:0] cmd_ncycles;
    logic                  res_valid;
    logic                  res_ready;
    logic [CH_W-1:0]       res_chan;
    logic [DATA_WIDTH-1:0] res_count;
    logic                  res_err;

    modport master (
        output cmd_valid, cmd_chan, cmd_ncycles, res_ready,
        input  cmd_ready, res_valid, res_chan, res_count, res_err
    );

    modport slave (
        input  cmd_valid, cmd_chan, cmd_ncycles, res_ready,
        output cmd_ready, res_valid, res_chan, res_count, res_err
    );
endinterface

// File: rtl/freq_meas_sequencer.sv
// Sequences one shared frequency-measurement counter across N_CHAN DUT pins.
// A command (channel, window length) selects a pin, waits for the counter's
// input synchronizer to flush, pulses the counter enable, waits for done and
// returns the number of rising edges seen in the window.
// Ports:
//   Clock, nReset      system clock, asynchronous active-low reset
//   bus (slave)        command / result valid-ready handshakes
//   busy               sequencer not idle
//   sig_in             raw DUT pins
//   meas_wave          selected pin to counter in_wave (registered select)
//   meas_enable        one-cycle counter start pulse
//   meas_ncycles       window length to the counter, held for the operation
//   meas_done          counter done flag
//   meas_edge_count    counter free-running edge total
module freq_meas_sequencer #(
    parameter int DATA_WIDTH    = 16,
    parameter int N_CHAN        = 4,
    parameter int CH_W          = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int DRAIN_CYCLES  = 2,
    parameter int WD_MARGIN     = 8
) (
    input  logic                  Clock,
    input  logic                  nReset,
    freq_meas_sequencer_if.slave  bus,
    output logic                  busy,
    input  logic [N_CHAN-1:0]     sig_in,
    output logic                  meas_wave,
    output logic                  meas_enable,
    output logic [DATA_WIDTH-1:0] meas_ncycles,
    input  logic                  meas_done,
    input  logic [DATA_WIDTH-1:0] meas_edge_count
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;

    // Every encodable channel index gets a legality bit, so the range check
    // is a table lookup that stays valid when N_CHAN == 2**CH_W.
    localparam int NSEL = 1 << CH_W;
    localparam logic [NSEL-1:0] CHAN_OK = NSEL'((64'd1 << N_CHAN) - 64'd1);

    localparam int TMAX = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    logic [2:0]            state;
    logic [TW-1:0]         timer;
    logic [CH_W-1:0]       sel_q;
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH:0]   wd;
    logic [DATA_WIDTH:0]   wd_next;
    logic [DATA_WIDTH:0]   wd_limit;
    logic                  timer_last;
    logic [NSEL-1:0]       sig_ext;

    // Pad the pin vector to the full select range; unused selects read 0.
    for (genvar g = 0; g < NSEL; g++) begin : g_pad
        if (g < N_CHAN) begin : g_pin
            assign sig_ext[g] = sig_in[g];
        end else begin : g_zero
            assign sig_ext[g] = 1'b0;
        end
    end

    assign meas_wave     = sig_ext[sel_q];
    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.res_valid = (state == S_RESULT);
    assign busy          = (state != S_IDLE);

    // Extra bit so ncycles + margin never wraps.
    assign wd_limit   = {1'b0, meas_ncycles} + (DATA_WIDTH+1)'(WD_MARGIN);
    assign wd_next    = wd + (DATA_WIDTH+1)'(1);
    assign timer_last = (timer <= TW'(1));

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state         <= S_IDLE;
            timer         <= '0;
            sel_q         <= '0;
            base          <= '0;
            wd            <= '0;
            meas_enable   <= 1'b0;
            meas_ncycles  <= '0;
            bus.res_chan  <= '0;
            bus.res_count <= '0;
            bus.res_err   <= 1'b0;
        end else begin
            meas_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        sel_q        <= bus.cmd_chan;
                        meas_ncycles <= bus.cmd_ncycles;
                        if (bus.cmd_ncycles == '0 || !CHAN_OK[bus.cmd_chan]) begin
                            bus.res_chan  <= bus.cmd_chan;
                            bus.res_count <= '0;
                            bus.res_err   <= 1'b1;
                            state         <= S_RESULT;
                        end else begin
                            timer <= TW'(SETTLE_CYCLES);
                            state <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (timer_last) begin
                        // Registered, so the pulse lines up with the ARM cycle.
                        meas_enable <= 1'b1;
                        state       <= S_ARM;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_ARM: begin
                    base  <= meas_edge_count;
                    wd    <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    // wd == 0 only in the first RUN cycle; a done left over
                    // from the previous window is ignored there.
                    if (meas_done && wd != '0) begin
                        timer <= TW'(DRAIN_CYCLES);
                        state <= S_DRAIN;
                    end else if (wd_next >= wd_limit) begin
                        bus.res_chan  <= sel_q;
                        bus.res_count <= '0;
                        bus.res_err   <= 1'b1;
                        state         <= S_RESULT;
                    end else begin
                        wd <= wd_next;
                    end
                end
                S_DRAIN: begin
                    if (timer_last) begin
                        // Modular difference is correct across counter wrap.
                        bus.res_chan  <= sel_q;
                        bus.res_count <= meas_edge_count - base;
                        bus.res_err   <= 1'b0;
                        state         <= S_RESULT;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
